// File: rtl/grid_link_router.sv
// Neighbour-link router: steers local egress words to grid ports (unicast/broadcast/loopback)
// and merges grid ingress plus loopback into the local rx stream with a round-robin arbiter.
module grid_link_router #(
    parameter int unsigned NUM_GRID_PORTS       = 2,
    parameter int unsigned NUM_FPGAS            = 5,
    parameter int unsigned FPGA_ID              = 1,
    parameter int unsigned DEST_LSB             = 56,
    parameter logic [NUM_FPGAS*((NUM_GRID_PORTS > 1) ? $clog2(NUM_GRID_PORTS) : 1)-1:0]
                           ROUTE_MAP            = '0,
    parameter logic [NUM_GRID_PORTS-1:0] PORT_ENABLE = '1,
    parameter int unsigned ROUTER_DELAY_COUNTER = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  local_tx_data,
    input  logic                         local_tx_valid,
    output logic                         local_tx_ready,
    output logic [63:0]                  local_rx_data,
    output logic                         local_rx_valid,
    input  logic                         local_rx_ready,
    output logic [64*NUM_GRID_PORTS-1:0] grid_out_data,
    output logic [NUM_GRID_PORTS-1:0]    grid_out_valid,
    input  logic [NUM_GRID_PORTS-1:0]    grid_out_ready,
    input  logic [64*NUM_GRID_PORTS-1:0] grid_in_data,
    input  logic [NUM_GRID_PORTS-1:0]    grid_in_valid,
    output logic [NUM_GRID_PORTS-1:0]    grid_in_ready,
    output logic                         router_busy,
    output logic [15:0]                  drop_count
);

    localparam int unsigned N              = NUM_GRID_PORTS;
    localparam int unsigned FPGA_BIT_WIDTH = $clog2(NUM_FPGAS);
    localparam int unsigned PORT_W         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned MAP_SZ         = 1 << PORT_W;
    localparam int unsigned RR_W           = $clog2(N + 1);
    localparam int unsigned CNT_W          =
        (ROUTER_DELAY_COUNTER > 0) ? $clog2(ROUTER_DELAY_COUNTER + 1) : 1;
    localparam logic [FPGA_BIT_WIDTH-1:0] DEST_BCAST = '1;
    localparam logic [FPGA_BIT_WIDTH-1:0] DEST_SELF  = FPGA_BIT_WIDTH'(FPGA_ID);

    logic [N-1:0]       out_valid_q;
    logic [64*N-1:0]    out_data_q;
    logic               rx_valid_q;
    logic [63:0]        rx_data_q;
    logic [RR_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic               busy_q;
    logic [15:0]        drop_count_q;

    logic [FPGA_BIT_WIDTH-1:0] dest;
    logic               is_loop, is_bcast, is_drop, uni_ok;
    logic [PORT_W-1:0]  uni_port;
    logic [N-1:0]       out_free, out_load;
    logic [MAP_SZ-1:0]  en_pad, free_pad;
    logic               tx_fire, drop_fire;
    logic [N:0]         req, req_rdy, gnt;
    logic               rx_free, rx_load, blocked, activity;
    logic [RR_W:0]      rr_sum;
    logic [RR_W-1:0]    rr_idx, gnt_idx;
    logic [63:0]        rx_next;

    assign dest     = local_tx_data[DEST_LSB +: FPGA_BIT_WIDTH];
    assign en_pad   = MAP_SZ'(PORT_ENABLE);
    assign out_free = ~out_valid_q | grid_out_ready;
    assign free_pad = MAP_SZ'(out_free);

    // Destination decode, evaluated in priority order loopback > broadcast > drop > unicast.
    always_comb begin
        is_loop  = (dest == DEST_SELF);
        is_bcast = !is_loop && (dest == DEST_BCAST);
        is_drop  = !is_loop && !is_bcast && (32'(dest) >= NUM_FPGAS);
        uni_port = '0;
        if (!is_loop && !is_bcast && !is_drop) begin
            uni_port = ROUTE_MAP[32'(dest) * PORT_W +: PORT_W];
        end
        uni_ok = (32'(uni_port) < N) && en_pad[uni_port];
    end

    // Ingress arbitration: a requester is ready when no higher-priority requester is valid,
    // so a port's ready never depends on its own valid.
    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = grid_in_valid[i] & PORT_ENABLE[i];
        end
        req[N]  = local_tx_valid & is_loop;
        rx_free = !rx_valid_q || local_rx_ready;
        blocked = 1'b0;
        req_rdy = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = 0; k <= N; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
            if (rr_sum > (RR_W+1)'(N)) begin
                rr_sum = rr_sum - (RR_W+1)'(N + 1);
            end
            rr_idx = rr_sum[RR_W-1:0];
            req_rdy[rr_idx] = rx_free && !blocked;
            if (req[rr_idx]) begin
                blocked = 1'b1;
            end
        end
        gnt     = req & req_rdy;
        rx_load = |gnt;
        rx_next = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                rx_next = grid_in_data[64*k +: 64];
                gnt_idx = RR_W'(k);
            end
        end
        if (gnt[N]) begin
            rx_next = local_tx_data;
            gnt_idx = RR_W'(N);
        end
        for (int i = 0; i < N; i++) begin
            grid_in_ready[i] = PORT_ENABLE[i] ? req_rdy[i] : 1'b1;
        end
    end

    always_comb begin
        if (is_loop) begin
            local_tx_ready = req_rdy[N];
        end else if (is_bcast) begin
            local_tx_ready = &(out_free | ~PORT_ENABLE);
        end else if (is_drop || !uni_ok) begin
            local_tx_ready = 1'b1;
        end else begin
            local_tx_ready = free_pad[uni_port];
        end
        tx_fire   = local_tx_valid && local_tx_ready;
        drop_fire = tx_fire && !is_loop && !is_bcast && (is_drop || !uni_ok);
        for (int i = 0; i < N; i++) begin
            out_load[i] = tx_fire && !is_loop &&
                          ((is_bcast && PORT_ENABLE[i]) ||
                           (!is_bcast && !is_drop && uni_ok && (32'(uni_port) == i)));
        end
        activity = (|out_valid_q) || rx_valid_q || (|(grid_in_valid & PORT_ENABLE)) ||
                   local_tx_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= '0;
            out_data_q   <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rr_ptr_q     <= '0;
            idle_cnt_q   <= '0;
            busy_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (out_load[i]) begin
                    out_valid_q[i]        <= 1'b1;
                    out_data_q[64*i +: 64] <= local_tx_data;
                end else if (grid_out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
            if (rx_load) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_next;
                rr_ptr_q   <= (gnt_idx == RR_W'(N)) ? '0 : gnt_idx + RR_W'(1);
            end else if (local_rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (drop_fire && (drop_count_q != 16'hFFFF)) begin
                drop_count_q <= drop_count_q + 16'd1;
            end
            // Busy falls on the same edge the idle counter reaches zero.
            if (activity) begin
                idle_cnt_q <= CNT_W'(ROUTER_DELAY_COUNTER);
                busy_q     <= 1'b1;
            end else if (idle_cnt_q != '0) begin
                idle_cnt_q <= idle_cnt_q - CNT_W'(1);
                busy_q     <= (idle_cnt_q != CNT_W'(1));
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    always_comb begin
        grid_out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (PORT_ENABLE[i]) begin
                grid_out_data[64*i +: 64] = out_data_q[64*i +: 64];
            end
        end
    end

    assign grid_out_valid = out_valid_q & PORT_ENABLE;
    assign local_rx_valid = rx_valid_q;
    assign local_rx_data  = rx_data_q;
    assign router_busy    = busy_q;
    assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_grid_link_router.sv
// Scoreboard bench for grid_link_router: expected words queued at issue, popped by a monitor.
module tb_grid_link_router;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [63:0]  local_tx_data = '0;
    logic         local_tx_valid = 1'b0;
    logic         local_tx_ready;
    logic [63:0]  local_rx_data;
    logic         local_rx_valid;
    logic         local_rx_ready = 1'b1;
    logic [127:0] grid_out_data;
    logic [1:0]   grid_out_valid;
    logic [1:0]   grid_out_ready = 2'b11;
    logic [127:0] grid_in_data = '0;
    logic [1:0]   grid_in_valid = 2'b00;
    logic [1:0]   grid_in_ready;
    logic         router_busy;
    logic [15:0]  drop_count;

    logic [63:0]  d_tx_data = '0;
    logic         d_tx_valid = 1'b0;
    logic         d_tx_ready;
    logic [63:0]  d_rx_data;
    logic         d_rx_valid;
    logic [127:0] d_out_data;
    logic [1:0]   d_out_valid;
    logic [127:0] d_in_data = '0;
    logic [1:0]   d_in_valid = 2'b00;
    logic [1:0]   d_in_ready;
    logic         d_busy;
    logic [15:0]  d_drop;

    grid_link_router #(
        .NUM_GRID_PORTS(2), .NUM_FPGAS(5), .FPGA_ID(1), .DEST_LSB(56),
        .ROUTE_MAP(5'b01000), .PORT_ENABLE(2'b11), .ROUTER_DELAY_COUNTER(18)
    ) u_dut (
        .clk(clk), .reset(reset),
        .local_tx_data(local_tx_data), .local_tx_valid(local_tx_valid),
        .local_tx_ready(local_tx_ready),
        .local_rx_data(local_rx_data), .local_rx_valid(local_rx_valid),
        .local_rx_ready(local_rx_ready),
        .grid_out_data(grid_out_data), .grid_out_valid(grid_out_valid),
        .grid_out_ready(grid_out_ready),
        .grid_in_data(grid_in_data), .grid_in_valid(grid_in_valid),
        .grid_in_ready(grid_in_ready),
        .router_busy(router_busy), .drop_count(drop_count)
    );

    grid_link_router #(
        .NUM_GRID_PORTS(2), .NUM_FPGAS(5), .FPGA_ID(1), .DEST_LSB(56),
        .ROUTE_MAP(5'b01000), .PORT_ENABLE(2'b10), .ROUTER_DELAY_COUNTER(18)
    ) u_dis (
        .clk(clk), .reset(reset),
        .local_tx_data(d_tx_data), .local_tx_valid(d_tx_valid), .local_tx_ready(d_tx_ready),
        .local_rx_data(d_rx_data), .local_rx_valid(d_rx_valid), .local_rx_ready(1'b1),
        .grid_out_data(d_out_data), .grid_out_valid(d_out_valid), .grid_out_ready(2'b11),
        .grid_in_data(d_in_data), .grid_in_valid(d_in_valid), .grid_in_ready(d_in_ready),
        .router_busy(d_busy), .drop_count(d_drop)
    );

    int n_checks = 0;
    int n_pass = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] qrx[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] mk(input logic [2:0] dest, input logic [55:0] pay);
        return {5'b0, dest, pay};
    endfunction

    // Monitor: every output handshake must match the head of its expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (grid_out_valid[0] && grid_out_ready[0]) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL port0 word: got %h expected none", grid_out_data[63:0]);
                end else check("port0 word", grid_out_data[63:0], q0.pop_front());
            end
            if (grid_out_valid[1] && grid_out_ready[1]) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL port1 word: got %h expected none", grid_out_data[127:64]);
                end else check("port1 word", grid_out_data[127:64], q1.pop_front());
            end
            if (local_rx_valid && local_rx_ready) begin
                if (qrx.size() == 0) begin
                    n_checks++;
                    $display("FAIL rx word: got %h expected none", local_rx_data);
                end else check("rx word", local_rx_data, qrx.pop_front());
            end
        end
    end

    task automatic send(input logic [63:0] w, input string nm);
        local_tx_data  = w;
        local_tx_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (local_tx_ready) begin
                @(posedge clk);
                #1;
                local_tx_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL %s: local_tx_ready got 0 for 50 cycles expected 1", nm);
        local_tx_valid = 1'b0;
    endtask

    logic [63:0] aw[2];
    logic [63:0] bw[2];
    logic [63:0] lw[2];
    int i0, i1, il, cyc;
    logic h0, h1, hl, held_ok, dis_ok;
    logic [63:0] bc;

    task automatic drive_in();
        grid_in_valid[0]     = (i0 < 2);
        grid_in_valid[1]     = (i1 < 2);
        local_tx_valid       = (il < 2);
        grid_in_data[63:0]   = (i0 < 2) ? aw[i0] : 64'd0;
        grid_in_data[127:64] = (i1 < 2) ? bw[i1] : 64'd0;
        local_tx_data        = (il < 2) ? lw[il] : 64'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", grid_out_valid, 2'b00);
        check("reset out_data", grid_out_data[127:64] | grid_out_data[63:0], 64'd0);
        check("reset rx_valid", local_rx_valid, 1'b0);
        check("reset rx_data", local_rx_data, 64'd0);
        check("reset busy", router_busy, 1'b0);
        check("reset drop_count", drop_count, 16'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Unicast: dest 2 -> port0, dest 3 -> port1.
        q0.push_back(mk(3'd2, 56'h11));
        send(mk(3'd2, 56'h11), "uni0");
        check("uni port0 valid at t+1", grid_out_valid, 2'b01);
        q1.push_back(mk(3'd3, 56'h22));
        send(mk(3'd3, 56'h22), "uni1");
        check("uni port1 valid at t+2", grid_out_valid, 2'b10);
        check("uni drop_count", drop_count, 16'd0);
        repeat (2) @(posedge clk);
        #1;

        // Broadcast blocked by stalled occupied port1.
        grid_out_ready = 2'b01;
        q1.push_back(mk(3'd3, 56'h33));
        send(mk(3'd3, 56'h33), "bcast prefill");
        bc = mk(3'd7, 56'hBC);
        local_tx_data  = bc;
        local_tx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bcast stalled ready", local_tx_ready, 1'b0);
            check("bcast stalled no load", grid_out_valid, 2'b10);
        end
        @(posedge clk);
        #1;
        q0.push_back(bc);
        q1.push_back(bc);
        grid_out_ready = 2'b11;
        @(negedge clk);
        check("bcast ready on release", local_tx_ready, 1'b1);
        @(posedge clk);
        #1;
        local_tx_valid = 1'b0;
        check("bcast both loaded", grid_out_valid, 2'b11);
        @(posedge clk);
        #1;
        check("bcast shown once", grid_out_valid, 2'b00);

        // Out-of-range destination is dropped and counted.
        send(mk(3'd5, 56'h55), "drop");
        check("drop count", drop_count, 16'd1);
        check("drop no egress", grid_out_valid, 2'b00);

        // Reset while port1 stalls with a word.
        grid_out_ready = 2'b01;
        send(mk(3'd3, 56'h66), "stall");
        @(posedge clk);
        #1;
        check("stall holds word", grid_out_valid, 2'b10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset out_valid", grid_out_valid, 2'b00);
        check("midreset busy", router_busy, 1'b0);
        check("midreset drop_count", drop_count, 16'd0);
        reset = 1'b0;
        grid_out_ready = 2'b11;
        @(posedge clk);
        #1;

        // Busy deasserts 18 cycles after the last active cycle.
        q0.push_back(mk(3'd2, 56'h77));
        send(mk(3'd2, 56'h77), "busy word");
        @(posedge clk);
        #1;
        check("busy after drain", router_busy, 1'b1);
        held_ok = 1'b1;
        repeat (17) begin
            @(posedge clk);
            #1;
            if (router_busy !== 1'b1) held_ok = 1'b0;
        end
        check("busy held 17 idle cycles", held_ok, 1'b1);
        @(posedge clk);
        #1;
        check("busy drops at 18", router_busy, 1'b0);

        // Round-robin ingress: port0, port1, loopback.
        aw[0] = mk(3'd0, 56'hA0); aw[1] = mk(3'd0, 56'hA1);
        bw[0] = mk(3'd4, 56'hB0); bw[1] = mk(3'd4, 56'hB1);
        lw[0] = mk(3'd1, 56'hC0); lw[1] = mk(3'd1, 56'hC1);
        qrx.push_back(aw[0]); qrx.push_back(bw[0]); qrx.push_back(lw[0]);
        qrx.push_back(aw[1]); qrx.push_back(bw[1]); qrx.push_back(lw[1]);
        i0 = 0; i1 = 0; il = 0; cyc = 0;
        drive_in();
        while ((i0 + i1 + il) < 6 && cyc < 20) begin
            @(negedge clk);
            h0 = grid_in_valid[0] && grid_in_ready[0];
            h1 = grid_in_valid[1] && grid_in_ready[1];
            hl = local_tx_valid && local_tx_ready;
            check("one ingress grant per cycle", 2'(h0) + 2'(h1) + 2'(hl), 2'd1);
            @(posedge clk);
            #1;
            cyc++;
            if (h0) i0++;
            if (h1) i1++;
            if (hl) il++;
            drive_in();
        end
        check("ingress six grants in six cycles", 32'(cyc), 32'd6);
        repeat (3) @(posedge clk);
        #1;

        // Disabled port0 on the second instance.
        d_in_valid = 2'b01;
        d_in_data  = {64'd0, 64'hDEAD};
        d_tx_valid = 1'b1;
        dis_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_tx_data = mk(3'd2, 56'(k + 1));
            @(negedge clk);
            if (d_tx_ready !== 1'b1 || d_out_valid[0] !== 1'b0 || d_in_ready[0] !== 1'b1)
                dis_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        d_tx_valid = 1'b0;
        check("disabled port no stall, ready 1, no valid", dis_ok, 1'b1);
        @(posedge clk);
        #1;
        check("disabled drop_count", d_drop, 16'd3);
        check("disabled out_data zero", d_out_data[63:0], 64'd0);
        check("disabled ingress discarded", d_rx_valid, 1'b0);
        d_in_valid = 2'b00;

        check("port0 queue drained", 64'(q0.size()), 64'd0);
        check("port1 queue drained", 64'(q1.size()), 64'd0);
        check("rx queue drained", 64'(qrx.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
